// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// Module  : regfile_pkg
// Brief   : Shared defaults, state encoding and parity helper for regfile_sb.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  // Even parity bit: makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
//------------------------------------------------------------------------------
// Module  : regfile_scoreboard
// Brief   : Per-register pending bits with set-over-clear priority.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              set_ok,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              pend1,
  output logic              pend2
);

  localparam int c_NUM_REGS = 2**ADDR_W;

  logic [c_NUM_REGS-1:0] r_pend;
  logic                  w_clr1;
  logic                  w_clr2;
  logic                  w_r0_1;
  logic                  w_r0_2;

  // A new load issued behind a retiring one keeps the entry pending.
  for (genvar i = 0; i < c_NUM_REGS; i++) begin : g_pend
    always_ff @(posedge clk) begin
      if (rst) begin
        r_pend[i] <= 1'b0;
      end else if (set_ok && (set_addr == ADDR_W'(i))) begin
        r_pend[i] <= 1'b1;
      end else if (wr_ok && (waddr == ADDR_W'(i))) begin
        r_pend[i] <= 1'b0;
      end
    end
  end

  assign w_clr1 = wr_ok && (waddr == ra1) && !(set_ok && (set_addr == ra1));
  assign w_clr2 = wr_ok && (waddr == ra2) && !(set_ok && (set_addr == ra2));
  assign w_r0_1 = (R0_ZERO != 0) && (ra1 == '0);
  assign w_r0_2 = (R0_ZERO != 0) && (ra2 == '0);

  assign pend1 = run && !w_r0_1 && r_pend[ra1] && !w_clr1;
  assign pend2 = run && !w_r0_2 && r_pend[ra2] && !w_clr2;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
//------------------------------------------------------------------------------
// Module  : regfile_sb
// Brief   : 2R1W register file with write bypass, load scoreboard and a
//           post-reset hardware clear. Optional parity: REGFILE_PARITY_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              set_pend,
  input  logic [ADDR_W-1:0] set_addr,
  output logic              pend1,
  output logic              pend2,
  output logic              init_busy
`ifdef REGFILE_PARITY_EN
  ,
  input  logic              par_inj,
  output logic              par_err1,
  output logic              par_err2
`endif
);

  localparam int c_NUM_REGS = 2**ADDR_W;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [c_NUM_REGS];

  logic              w_run;
  logic              w_wr_ok;
  logic              w_set_ok;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic              w_r0_1;
  logic              w_r0_2;
  logic              w_byp1;
  logic              w_byp2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_clr_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      if (r_clr_cnt == '1) begin
        r_state <= ST_RUN;
      end else begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  assign init_busy = (r_state == ST_INIT);
  assign w_run     = (r_state == ST_RUN);
  assign w_wr_ok   = w_run && we       && ((waddr    != '0) || (R0_ZERO == 0));
  assign w_set_ok  = w_run && set_pend && ((set_addr != '0) || (R0_ZERO == 0));

  // The clear sequence borrows the single write port while in INIT.
  assign w_mem_we   = w_run ? w_wr_ok : !rst;
  assign w_mem_addr = w_run ? waddr : r_clr_cnt;
  assign w_mem_data = w_run ? wdata : '0;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  assign w_r0_1 = (R0_ZERO != 0) && (ra1 == '0);
  assign w_r0_2 = (R0_ZERO != 0) && (ra2 == '0);
  assign w_byp1 = w_wr_ok && (waddr == ra1);
  assign w_byp2 = w_wr_ok && (waddr == ra2);

  assign rd1 = (!w_run || w_r0_1) ? '0 : (w_byp1 ? wdata : r_mem[ra1]);
  assign rd2 = (!w_run || w_r0_2) ? '0 : (w_byp2 ? wdata : r_mem[ra2]);

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .run      (w_run),
    .wr_ok    (w_wr_ok),
    .waddr    (waddr),
    .set_ok   (w_set_ok),
    .set_addr (set_addr),
    .ra1      (ra1),
    .ra2      (ra2),
    .pend1    (pend1),
    .pend2    (pend2)
  );

`ifdef REGFILE_PARITY_EN
  logic r_par [c_NUM_REGS];
  logic w_par_bit;

  assign w_par_bit = w_run ? (even_parity(64'(wdata)) ^ par_inj) : 1'b0;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_par[w_mem_addr] <= w_par_bit;
    end
  end

  assign par_err1 = w_run && !w_r0_1 && !w_byp1 &&
                    (even_parity(64'(r_mem[ra1])) != r_par[ra1]);
  assign par_err2 = w_run && !w_r0_2 && !w_byp2 &&
                    (even_parity(64'(r_mem[ra2])) != r_par[ra2]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
//------------------------------------------------------------------------------
// Module  : tb_regfile_sb
// Brief   : Directed and random checks of regfile_sb against an array model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic        set_pend = 1'b0;
  logic [4:0]  set_addr = '0;
  logic        par_inj = 1'b0;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        pend1;
  logic        pend2;
  logic        init_busy;
`ifdef REGFILE_PARITY_EN
  logic        par_err1;
  logic        par_err2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents, pending flags, corrupted-parity flags.
  logic [31:0] m_mem  [32];
  bit          m_pend [32];
  bit          m_bad  [32];
  bit          m_init  = 1'b0;
  bit          m_valid = 1'b0;
  int          m_cnt   = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .R0_ZERO (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .set_pend  (set_pend),
    .set_addr  (set_addr),
    .pend1     (pend1),
    .pend2     (pend2),
    .init_busy (init_busy)
`ifdef REGFILE_PARITY_EN
    ,
    .par_inj   (par_inj),
    .par_err1  (par_err1),
    .par_err2  (par_err2)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (m_init || ra == 5'd0) return 32'h0;
    if (we && waddr != 5'd0 && waddr == ra) return wdata;
    return m_mem[ra];
  endfunction

  function automatic logic exp_pend(input logic [4:0] ra);
    if (m_init || ra == 5'd0) return 1'b0;
    if (we && waddr != 5'd0 && waddr == ra && !(set_pend && set_addr == ra)) return 1'b0;
    return m_pend[ra];
  endfunction

  function automatic logic exp_perr(input logic [4:0] ra);
    if (m_init || ra == 5'd0) return 1'b0;
    if (we && waddr == ra) return 1'b0;
    return m_bad[ra];
  endfunction

  // Called just after a falling edge: compare outputs, then advance one cycle.
  task automatic tick();
    #1;
    if (m_valid) begin
      check_val("rd1", rd1, exp_rd(ra1));
      check_val("rd2", rd2, exp_rd(ra2));
      check_val("pend1", 32'(pend1), 32'(exp_pend(ra1)));
      check_val("pend2", 32'(pend2), 32'(exp_pend(ra2)));
      check_val("init_busy", 32'(init_busy), 32'(m_init));
`ifdef REGFILE_PARITY_EN
      check_val("par_err1", 32'(par_err1), 32'(exp_perr(ra1)));
      check_val("par_err2", 32'(par_err2), 32'(exp_perr(ra2)));
`endif
    end
    @(posedge clk);
    if (rst) begin
      m_init  = 1'b1;
      m_cnt   = 0;
      m_valid = 1'b1;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else if (m_init) begin
      m_mem[m_cnt] = 32'h0;
      m_bad[m_cnt] = 1'b0;
      if (m_cnt == 31) m_init = 1'b0;
      else m_cnt++;
    end else begin
      if (we && waddr != 5'd0) begin
        m_mem[waddr]  = wdata;
        m_pend[waddr] = 1'b0;
        m_bad[waddr]  = par_inj;
      end
      if (set_pend && set_addr != 5'd0) m_pend[set_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    for (int k = 0; k < 40 && init_busy; k++) begin
      n++;
      tick();
    end
    check_val(tag, 32'(n), 32'd32);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ra1 = 5'd31;
    count_busy("init_len");
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1 check_val("clr_rd", rd1, 32'h0);
      tick();
    end

    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; ra1 = 5'd5;
    #1 check_val("byp_x5", rd1, 32'hDEADBEEF);
    tick();
    we = 1'b0;
    #1 check_val("stored_x5", rd1, 32'hDEADBEEF);
    tick();

    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    tick();
    we = 1'b0; ra2 = 5'd0;
    #1 check_val("x0_rd", rd2, 32'h0);
    set_pend = 1'b1; set_addr = 5'd0;
    tick();
    set_pend = 1'b0;
    #1 check_val("x0_pend", 32'(pend2), 32'd0);
    tick();

    set_pend = 1'b1; set_addr = 5'd7;
    tick();
    set_pend = 1'b0; ra1 = 5'd7;
    #1 check_val("x7_pend_set", 32'(pend1), 32'd1);
    we = 1'b1; waddr = 5'd7; wdata = 32'h42;
    #1 check_val("x7_pend_wr", 32'(pend1), 32'd0);
    check_val("x7_byp", rd1, 32'h42);
    tick();
    we = 1'b0; set_pend = 1'b1;
    tick();
    we = 1'b1; wdata = 32'h43;
    #1 check_val("x7_set_wr", 32'(pend1), 32'd1);
    tick();
    we = 1'b0; set_pend = 1'b0;
    #1 check_val("x7_still_pend", 32'(pend1), 32'd1);
    tick();

    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    tick();
    we = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
    count_busy("reinit_len");
    we = 1'b0; ra1 = 5'd3;
    #1 check_val("x3_cleared", rd1, 32'h0);
    tick();

`ifdef REGFILE_PARITY_EN
    we = 1'b1; waddr = 5'd9; wdata = 32'h1; par_inj = 1'b1;
    tick();
    we = 1'b0; par_inj = 1'b0; ra1 = 5'd9;
    #1 check_val("par_inj_err", 32'(par_err1), 32'd1);
    tick();
    we = 1'b1;
    tick();
    we = 1'b0;
    #1 check_val("par_ok", 32'(par_err1), 32'd0);
    tick();
`endif

    for (int i = 0; i < 500; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      we       = 1'($urandom_range(0, 1));
      waddr    = 5'($urandom_range(0, 7));
      wdata    = $urandom;
      ra1      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra2      = 5'($urandom_range(0, 7));
      set_pend = ($urandom_range(0, 2) == 0);
      set_addr = 5'($urandom_range(0, 7));
      par_inj  = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
